// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: PS/2 receive path -- sync, glitch filter, 11-bit deframer
// and scan-code set 2 make/break/E0 decoder with held key outputs.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [7:0] keyCode,
  output logic       keypress,
  output logic       extended,
  output logic       key_valid,
  output logic       frame_err
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
  logic [1:0]            clk_s, dat_s;
  logic [FILTER_LEN-1:0] hist;
  logic                  filt, filt_d, sample, good, timeout;
  state_t                state;
  logic [2:0]            bitcnt;
  logic [7:0]            shreg;
  logic                  par, ext_flag, brk_flag;
  logic [TW-1:0]         tcnt;
  assign sample  = filt_d & ~filt;
  assign good    = dat_s[1] & ^{shreg, par};
  assign timeout = state != IDLE && tcnt == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      clk_s  <= '1;
      dat_s  <= '1;
      hist   <= '1;
      filt   <= 1'b1;
      filt_d <= 1'b1;
    end else begin
      clk_s  <= {clk_s[0], PS2_CLK};
      dat_s  <= {dat_s[0], PS2_DAT};
      hist   <= {hist[FILTER_LEN-2:0], clk_s[1]};
      filt   <= &hist ? 1'b1 : (|hist ? filt : 1'b0);
      filt_d <= filt;
    end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shreg     <= '0;
      par       <= 1'b0;
      tcnt      <= '0;
      ext_flag  <= 1'b0;
      brk_flag  <= 1'b0;
      keyCode   <= '0;
      keypress  <= 1'b0;
      extended  <= 1'b0;
      key_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      frame_err <= 1'b0;
      if (timeout) begin
        state     <= IDLE;
        tcnt      <= '0;
        frame_err <= 1'b1;
        ext_flag  <= 1'b0;
        brk_flag  <= 1'b0;
      end else if (sample) begin
        tcnt <= '0;
        case (state)
          IDLE:
            if (dat_s[1]) frame_err <= 1'b1;
            else begin
              state  <= DATA;
              bitcnt <= '0;
            end
          DATA: begin
            shreg  <= {dat_s[1], shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par   <= dat_s[1];
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            // prefixes only arm flags; any other good byte is a key event
            if (!good) begin
              frame_err <= 1'b1;
              ext_flag  <= 1'b0;
              brk_flag  <= 1'b0;
            end else if (shreg == 8'hE0) ext_flag <= 1'b1;
            else if (shreg == 8'hF0) brk_flag <= 1'b1;
            else begin
              keyCode   <= shreg;
              keypress  <= ~brk_flag;
              extended  <= ext_flag;
              key_valid <= 1'b1;
              ext_flag  <= 1'b0;
              brk_flag  <= 1'b0;
            end
          end
        endcase
      end else tcnt <= state != IDLE ? tcnt + 1'b1 : '0;
    end
endmodule
